// File: rtl/vga_timing_pkg.sv
// Shared raster constants and types for the VGA timing generator.
// Default values describe 640x480@60 with a 25 MHz-class pixel tick.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COORD_MAX = 1 << COORD_W;
  localparam int unsigned DIV_MAX   = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // True when v lies in [first, first+len-1].
  function automatic logic in_window(coord_t v, int unsigned first, int unsigned len);
    return (32'(v) >= first) && (32'(v) < first + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_tick.sv
// Pixel-tick divider: pix_en is high for one clk out of every CLK_DIV.
// With CLK_DIV=1 the counter never leaves zero and pix_en stays high.
module pix_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > DIV_MAX) begin : g_div_range_chk
    $error("pix_tick_gen: CLK_DIV must be 1..%0d", DIV_MAX);
  end

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  assign pix_en = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: scan counters, blanking/frame markers, and the output
// register that aligns sync and colour on the same pixel tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter int unsigned CLK_DIV     = 2,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       vblank,
  output logic       frame_start,
  input  logic [7:0] rgb_r_in,
  input  logic [7:0] rgb_g_in,
  input  logic [7:0] rgb_b_in,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t      H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t      V_LAST  = coord_t'(V_TOTAL - 1);

  if (H_TOTAL > COORD_MAX) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds %0d", COORD_MAX);
  end
  if (V_TOTAL > COORD_MAX) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds %0d", COORD_MAX);
  end
  if (CLK_DIV < 1 || CLK_DIV > DIV_MAX) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV must be 1..%0d", DIV_MAX);
  end

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  rgb_t   rgb_q, rgb_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;

  assign video_on    = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
  assign vblank      = (32'(y_q) >= V_ACTIVE);
  assign frame_start = pix_en && (x_q == '0) && (y_q == '0);

  always_comb begin
    // NOTE: every output starts from its held value, so no path leaves one unassigned (no latch).
    x_d   = x_q;
    y_d   = y_q;
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (pix_en) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
      end else begin
        x_d = x_q + coord_t'(1);
      end
      // Sync and colour are both captured from the position presented now.
      rgb_d = video_on ? rgb_t'{r: rgb_r_in, g: rgb_g_in, b: rgb_b_in} : '0;
      hs_d  = in_window(x_q, H_ACTIVE + H_FP, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_d  = in_window(y_q, V_ACTIVE + V_FP, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      rgb_q <= '0;
      hs_q  <= ~SYNC_ACTIVE;
      vs_q  <= ~SYNC_ACTIVE;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign pixel_x = x_q;
  assign pixel_y = y_q;
  assign vga_r   = rgb_q.r;
  assign vga_g   = rgb_q.g;
  assign vga_b   = rgb_q.b;
  assign vga_hs  = hs_q;
  assign vga_vs  = vs_q;

endmodule
